mcp_send_arb: RTL and testbench

//  Source-side (clk_a) controller for the MCP CDC transmitter. Arbitrates NREQ

---
 rtl/mcp_pkg.sv | 24 ++
 rtl/mcp_send_arb_if.sv | 32 +++
 rtl/mcp_rr_arb.sv | 40 ++++
 rtl/mcp_send_arb.sv | 152 +++++++++++++++
 tb/tb_mcp_send_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp_pkg.sv
// Shared types and helpers for the MCP source-side send arbiter.
package mcp_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSend   = 2'd1,
        StWaitLo = 2'd2,
        StWaitHi = 2'd3
    } state_e;

    localparam int unsigned StateW         = 2;
    localparam int unsigned TimeoutDefault = 64;

    // Minimum width of 1 so a single-entry index still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mcp_send_arb_if.sv
// Requester and MCP A-side handshake bundle for mcp_send_arb.
interface mcp_send_arb_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned NREQ   = 4
);
    import mcp_pkg::*;

    localparam int unsigned IdW = clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   aready;
    logic                   asend;
    logic [DWIDTH-1:0]      adatain;
    logic                   busy;
    logic [IdW-1:0]         gnt_id;
    logic                   timeout;

    // Requesters plus the mcp transmitter side.
    modport master (
        output req_valid, req_data, aready,
        input  req_ready, asend, adatain, busy, gnt_id, timeout
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_data, aready,
        output req_ready, asend, adatain, busy, gnt_id, timeout
    );

endinterface

// File: rtl/mcp_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module mcp_rr_arb
    import mcp_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IdW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdW-1:0]  idx_o,
    output logic            any_o
);

    localparam int unsigned SumW = IdW + 1;

    logic [SumW-1:0] sum;
    logic [IdW-1:0]  cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_i} + SumW'(i);
            if (sum >= SumW'(NREQ)) begin
                sum = sum - SumW'(NREQ);
            end
            cand = sum[IdW-1:0];
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mcp_send_arb.sv
// Source-side MCP send controller: round-robin grant, one word per asend/aready handshake.
// Optional watchdog enabled by defining MCP_ARB_TIMEOUT_EN.
module mcp_send_arb
    import mcp_pkg::*;
#(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input logic           clk_a,
    input logic           rstn_a,
    mcp_send_arb_if.slave bus
);

    localparam int unsigned IdW = clog2(NREQ);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("mcp_send_arb: NREQ must be 2..16");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mcp_send_arb: TIMEOUT must be at least 2");
    end

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    gnt_id_q, gnt_id_d;
    logic [DWIDTH-1:0] adatain_q, adatain_d;
    logic              asend_q, asend_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IdW-1:0]    arb_idx;
    logic              arb_any;
    logic              grant;
    logic              expire;
    logic [DWIDTH-1:0] sel_data;

    mcp_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Reset gating keeps req_ready quiet while rstn_a is held low.
    assign grant         = rstn_a && (state_q == StIdle) && bus.aready && arb_any;
    assign bus.req_ready = grant ? arb_gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = bus.req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

`ifdef MCP_ARB_TIMEOUT_EN
    localparam int unsigned CntW = clog2(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Cleared in IDLE and SEND, so every WAIT_LO entry starts from zero.
    always_comb begin
        cnt_d = '0;
        if (state_q == StWaitLo || state_q == StWaitHi) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk_a or negedge rstn_a) begin
        if (!rstn_a) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        adatain_d = adatain_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    adatain_d = sel_data;
                    gnt_id_d  = arb_idx;
                    ptr_d     = (arb_idx == IdW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: state_d = StWaitLo;
            StWaitLo: begin
                if (!bus.aready) begin
                    state_d = StWaitHi;
                end else if (expire) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StWaitHi: begin
                if (bus.aready) begin
                    state_d = StIdle;
                end else if (expire) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        asend_d = (state_d == StSend);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk_a or negedge rstn_a) begin
        if (!rstn_a) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_id_q  <= '0;
            adatain_q <= '0;
            asend_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            adatain_q <= adatain_d;
            asend_q   <= asend_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.asend   = asend_q;
    assign bus.adatain = adatain_q;
    assign bus.busy    = busy_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mcp_send_arb.sv
// Directed plus randomized bench for mcp_send_arb against a transaction-level model.
module tb_mcp_send_arb;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    mcp_send_arb_if #(.DWIDTH(DW), .NREQ(NR)) bus ();

    mcp_send_arb #(
        .DWIDTH  (DW),
        .NREQ    (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk_a  (clk),
        .rstn_a (rstn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mdata [NR];
    int            m_ptr;
    int            waits [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        mdata[i] = v;
        bus.req_data[i*DW +: DW] = v;
    endtask

    // Spec rule: first pending requester at or above the pointer, wrapping.
    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // From SEND with aready=1: hold aready high lo cycles, low hi cycles, then high.
    task automatic handshake(input int lo, input int hi, input logic [DW-1:0] d);
        tick();
        check("asend_one_cycle", 32'(bus.asend), 0);
        for (int k = 0; k < lo; k++) begin
            tick();
            check("wait_lo_busy", 32'(bus.busy), 1);
            check("wait_lo_no_ready", 32'(bus.req_ready), 0);
        end
        bus.aready = 1'b0;
        for (int k = 0; k < hi; k++) begin
            tick();
            check("wait_busy", 32'(bus.busy), 1);
            check("wait_adatain_hold", 32'(bus.adatain), 32'(d));
            check("wait_no_asend", 32'(bus.asend), 0);
        end
        bus.aready = 1'b1;
        tick();
        check("idle_busy_low", 32'(bus.busy), 0);
        check("idle_adatain_hold", 32'(bus.adatain), 32'(d));
        check("idle_no_timeout", 32'(bus.timeout), 0);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        m_ptr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] pend;
        logic [NR-1:0] fresh;
        int            w;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.aready    = 1'b0;
        for (int i = 0; i < NR; i++) mdata[i] = '0;
        #2;
        rstn = 1'b0;
        bus.aready    = 1'b1;
        bus.req_valid = 4'b0001;
        set_data(0, 8'hA5);
        #1;
        check("rst_asend", 32'(bus.asend), 0);
        check("rst_adatain", 32'(bus.adatain), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        tick();
        tick();
        rstn  = 1'b1;
        m_ptr = 0;

        // Single request
        #1;
        check("t1_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        check("t1_asend", 32'(bus.asend), 1);
        check("t1_adatain", 32'(bus.adatain), 32'hA5);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_gnt_id", 32'(bus.gnt_id), 0);
        check("t1_ready_off", 32'(bus.req_ready), 0);
        bus.req_valid = '0;

        // Handshake with aready low for 6 cycles
        handshake(0, 6, 8'hA5);

        // Round robin from a fresh pointer
        pulse_reset();
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_req_ready", 32'(bus.req_ready), 32'(1 << (k % NR)));
            tick();
            check("t3_asend", 32'(bus.asend), 1);
            check("t3_gnt_id", 32'(bus.gnt_id), 32'(k % NR));
            check("t3_adatain", 32'(bus.adatain), 32'(8'h10 + (k % NR)));
            handshake(0, 1, 8'(8'h10 + (k % NR)));
        end
        m_ptr = 1;

        // Blocked while aready is low
        bus.aready    = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        check("t4_blocked_ready", 32'(bus.req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_blocked_asend", 32'(bus.asend), 0);
            check("t4_blocked_busy", 32'(bus.busy), 0);
        end
        bus.aready = 1'b1;
        #1;
        check("t4_grant_ready", 32'(bus.req_ready), 32'h4);
        tick();
        check("t4_asend", 32'(bus.asend), 1);
        check("t4_gnt_id", 32'(bus.gnt_id), 2);
        check("t4_adatain", 32'(bus.adatain), 32'h12);
        bus.req_valid = '0;

        // Reset while in WAIT_HI; pointer must return to 0
        tick();
        bus.aready = 1'b0;
        tick();
        tick();
        check("t5_pre_busy", 32'(bus.busy), 1);
        rstn = 1'b0;
        #1;
        check("t5_asend", 32'(bus.asend), 0);
        check("t5_adatain", 32'(bus.adatain), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_gnt_id", 32'(bus.gnt_id), 0);
        bus.aready    = 1'b1;
        bus.req_valid = 4'b1001;
        set_data(0, 8'h77);
        set_data(3, 8'h33);
        rstn = 1'b1;
        #1;
        check("t5_ptr_zero", 32'(bus.req_ready), 32'h1);
        tick();
        check("t5_asend", 32'(bus.asend), 1);
        check("t5_adatain_new", 32'(bus.adatain), 32'h77);
        bus.req_valid = '0;
        handshake(1, 2, 8'h77);

        // Watchdog: aready stays low after asend
        bus.req_valid = 4'b0010;
        set_data(1, 8'h5C);
        #1;
        check("t6_req_ready", 32'(bus.req_ready), 32'h2);
        tick();
        check("t6_asend", 32'(bus.asend), 1);
        bus.req_valid = '0;
        bus.aready    = 1'b0;
        tick();
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t6_no_early_timeout", 32'(bus.timeout), 0);
        end
        tick();
`ifdef MCP_ARB_TIMEOUT_EN
        check("t6_timeout_pulse", 32'(bus.timeout), 1);
        check("t6_timeout_idle", 32'(bus.busy), 0);
`else
        check("t6_timeout_off", 32'(bus.timeout), 0);
        check("t6_still_waiting", 32'(bus.busy), 1);
`endif
        tick();
        check("t6_timeout_one_cycle", 32'(bus.timeout), 0);
        bus.aready = 1'b1;
        tick();
        check("t6_recover_idle", 32'(bus.busy), 0);

        // Randomized traffic against the model
        pulse_reset();
        pend = '0;
        for (int i = 0; i < NR; i++) waits[i] = 0;
        for (int n = 0; n < 40; n++) begin
            fresh = 4'($urandom_range(0, 15)) & ~pend;
            for (int i = 0; i < NR; i++) begin
                if (fresh[i]) set_data(i, 8'($urandom));
            end
            pend          = pend | fresh;
            bus.req_valid = pend;
            #1;
            w = pick(pend, m_ptr);
            if (w < 0) begin
                check("rnd_idle_ready", 32'(bus.req_ready), 0);
                tick();
                check("rnd_idle_asend", 32'(bus.asend), 0);
                continue;
            end
            check("rnd_req_ready", 32'(bus.req_ready), 32'(1 << w));
            tick();
            check("rnd_asend", 32'(bus.asend), 1);
            check("rnd_gnt_id", 32'(bus.gnt_id), 32'(w));
            check("rnd_adatain", 32'(bus.adatain), 32'(mdata[w]));
            check("rnd_starvation", 32'(waits[w] <= NR - 1), 1);
            waits[w] = 0;
            for (int i = 0; i < NR; i++) begin
                if (i != w && pend[i]) waits[i]++;
            end
            m_ptr         = (w + 1) % NR;
            pend[w]       = 1'b0;
            bus.req_valid = pend;
            handshake(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), mdata[w]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
